uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: word FIFO feeding an 8N1 UART transmitter.
// Each FIFO word is sent as WORD_BYTES back-to-back frames, in the byte order
// chosen by MSB_FIRST. Each word starts either on an enable pulse or, with
// AUTO_MODE=1, automatically while the FIFO is non-empty.
// Ports:
//   clk, rst_n      - clock; synchronous active-low reset
//   fifo_din        - word to enqueue (8*WORD_BYTES bits)
//   fifo_wr_en      - write strobe; dropped when full (sets overflow)
//   fifo_full/empty - registered FIFO status
//   fifo_level      - registered word count (0..2^FIFO_AW)
//   overflow        - sticky dropped-write flag
//   enable          - start pulse (manual mode only)
//   uart_tx         - serial line, idle high
//   busy            - high from LOAD through the last stop bit
//   word_done       - 1-cycle pulse after the last stop bit of a word
module uart_word_tx #(
  parameter int BAUD_DIV   = 216,
  parameter int CNT_WIDTH  = 8,
  parameter int WORD_BYTES = 8,
  parameter int FIFO_AW    = 4,
  parameter int MSB_FIRST  = 0,
  parameter int AUTO_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*WORD_BYTES-1:0] fifo_din,
  input  logic                    fifo_wr_en,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    overflow,
  input  logic                    enable,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    word_done
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(BAUD_DIV - 1);
  localparam logic [4:0]           LAST_BYTE = 5'(WORD_BYTES - 1);
  localparam logic [FIFO_AW:0]     FULL_LVL  = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

  state_e                 state_q;
  logic [W-1:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]     wptr_q, rptr_q;
  logic [FIFO_AW:0]       level_q, level_d;
  logic                   full_q, empty_q, ovf_q;
  logic [W-1:0]           pop_word_q, shreg_q, shreg_nxt;
  logic [7:0]             tx_byte_q, cur_byte;
  logic [2:0]             bit_cnt_q;
  logic [4:0]             byte_cnt_q;
  logic [CNT_WIDTH-1:0]   baud_cnt_q;
  logic                   tx_q, busy_q, done_q;
  logic                   baud_tick, last_byte, word_end, start_req, pop, wr_acc;

  assign baud_tick = (baud_cnt_q == BAUD_LAST);
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign word_end  = (state_q == S_STOP) && baud_tick && last_byte;
  assign start_req = (AUTO_MODE != 0) || enable;
  // Pop from IDLE on a start request, or straight out of the last stop bit in
  // auto mode so the next word's LOAD follows word_done with no idle cycle.
  assign pop    = !empty_q && (((state_q == S_IDLE) && start_req) ||
                               (word_end && (AUTO_MODE != 0)));
  assign wr_acc = fifo_wr_en && !full_q;

  // Byte order is realised by shifting the word register toward the end that
  // is sent first.
  assign cur_byte  = (MSB_FIRST != 0) ? shreg_q[W-1 -: 8] : shreg_q[7:0];
  assign shreg_nxt = (MSB_FIRST != 0) ? (shreg_q << 8) : (shreg_q >> 8);

  always_comb begin
    level_d = level_q;
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wptr_q] <= fifo_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      pop_word_q <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop) begin
        rptr_q     <= rptr_q + FIFO_AW'(1);
        pop_word_q <= mem[rptr_q];
      end
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
      if (fifo_wr_en && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= '0;
      tx_byte_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      baud_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE || state_q == S_LOAD || baud_tick) baud_cnt_q <= '0;
      else                                                     baud_cnt_q <= baud_cnt_q + CNT_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          shreg_q    <= pop_word_q;
          byte_cnt_q <= '0;
          tx_q       <= 1'b0;
          state_q    <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            tx_byte_q <= cur_byte;
            shreg_q   <= shreg_nxt;
            tx_q      <= cur_byte[0];
            bit_cnt_q <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q      <= tx_byte_q[1];
              tx_byte_q <= tx_byte_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            byte_cnt_q <= byte_cnt_q + 5'd1;
            if (last_byte) begin
              done_q <= 1'b1;
              if (pop) begin
                state_q <= S_LOAD;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign word_done  = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three instances (defaults; MSB-first 4-byte fast
// baud; auto-mode 3-byte fast baud) checked every cycle against a queue-based
// line model, plus literal expectations for latency, byte order and FIFO limits.
module tb_uart_word_tx;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n [NI];
  logic         wr_en [NI];
  logic         en    [NI];
  logic [127:0] din   [NI];
  logic         tx [NI], busy [NI], done [NI], full [NI], empty [NI], ovf [NI];
  logic [4:0]   lvl [NI];

  uart_word_tx u0 (
    .clk(clk), .rst_n(rst_n[0]), .fifo_din(din[0][63:0]), .fifo_wr_en(wr_en[0]),
    .fifo_full(full[0]), .fifo_empty(empty[0]), .fifo_level(lvl[0]), .overflow(ovf[0]),
    .enable(en[0]), .uart_tx(tx[0]), .busy(busy[0]), .word_done(done[0]));

  uart_word_tx #(.BAUD_DIV(4), .CNT_WIDTH(8), .WORD_BYTES(4), .FIFO_AW(4),
                 .MSB_FIRST(1), .AUTO_MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .fifo_din(din[1][31:0]), .fifo_wr_en(wr_en[1]),
    .fifo_full(full[1]), .fifo_empty(empty[1]), .fifo_level(lvl[1]), .overflow(ovf[1]),
    .enable(en[1]), .uart_tx(tx[1]), .busy(busy[1]), .word_done(done[1]));

  uart_word_tx #(.BAUD_DIV(4), .CNT_WIDTH(8), .WORD_BYTES(3), .FIFO_AW(4),
                 .MSB_FIRST(0), .AUTO_MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .fifo_din(din[2][23:0]), .fifo_wr_en(wr_en[2]),
    .fifo_full(full[2]), .fifo_empty(empty[2]), .fifo_level(lvl[2]), .overflow(ovf[2]),
    .enable(en[2]), .uart_tx(tx[2]), .busy(busy[2]), .word_done(done[2]));

  int bd_m  [NI] = '{216, 4, 4};
  int wb_m  [NI] = '{8, 4, 3};
  int msb_m [NI] = '{0, 1, 0};
  int aut_m [NI] = '{0, 0, 1};

  // Model: FIFO as a ring of words, plus the word on the line described only by
  // its value and how many cycles have passed since it was popped.
  logic [127:0] mq [NI][16];
  int           mh [NI], mc [NI], moff [NI];
  logic [127:0] mw [NI];
  bit           mact [NI], movf [NI], mdone [NI];

  int ncmp = 0, nfail = 0, cyc = 0, en_edge = 0;
  int log_sel = -1;
  bit txlog [$];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Line level for the word in flight: 1 idle/LOAD cycle, then frames of
  // 10 bit-times (start, 8 data LSB first, stop) of bd cycles each.
  function automatic logic exp_tx(input int i);
    int idx, fr, pos, sel;
    if (!mact[i] || moff[i] == 0) return 1'b1;
    idx = (moff[i] - 1) / bd_m[i];
    fr  = idx / 10;
    pos = idx % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    sel = (msb_m[i] != 0) ? (wb_m[i] - 1 - fr) : fr;
    return mw[i][8*sel + pos - 1];
  endfunction

  task automatic step(input int i);
    bit start, acc;
    if (!rst_n[i]) begin
      mh[i] = 0; mc[i] = 0; moff[i] = 0; mact[i] = 0; movf[i] = 0; mdone[i] = 0;
    end else begin
      start = 0;
      mdone[i] = 0;
      if (mact[i]) begin
        moff[i]++;
        if (moff[i] == 1 + 10 * wb_m[i] * bd_m[i]) begin
          mact[i] = 0;
          mdone[i] = 1;
          if (aut_m[i] != 0 && mc[i] > 0) start = 1;
        end
      end else if (mc[i] > 0 && (aut_m[i] != 0 || en[i])) start = 1;
      acc = wr_en[i] && mc[i] < 16;
      if (wr_en[i] && mc[i] == 16) movf[i] = 1;
      if (start) begin
        mw[i] = mq[i][mh[i]];
        mh[i] = (mh[i] + 1) % 16;
        mc[i]--;
        mact[i] = 1;
        moff[i] = 0;
      end
      if (acc) begin
        mq[i][(mh[i] + mc[i]) % 16] = din[i];
        mc[i]++;
      end
    end
  endtask

  // Model step at each rising edge, compare shortly after it.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) step(i);
      #1;
      for (int i = 0; i < NI; i++) begin
        chk("uart_tx",    i, 32'(tx[i]),    32'(exp_tx(i)));
        chk("busy",       i, 32'(busy[i]),  32'(mact[i]));
        chk("word_done",  i, 32'(done[i]),  32'(mdone[i]));
        chk("fifo_level", i, 32'(lvl[i]),   32'(mc[i]));
        chk("fifo_full",  i, 32'(full[i]),  32'(mc[i] == 16));
        chk("fifo_empty", i, 32'(empty[i]), 32'(mc[i] == 0));
        chk("overflow",   i, 32'(ovf[i]),   32'(movf[i]));
      end
      if (log_sel >= 0 && busy[log_sel]) txlog.push_back(tx[log_sel]);
    end
  end

  task automatic wr(input int i, input logic [127:0] d);
    @(negedge clk);
    din[i] = d; wr_en[i] = 1'b1;
    @(negedge clk);
    wr_en[i] = 1'b0;
  endtask

  task automatic pulse_en(input int i);
    @(negedge clk);
    en[i] = 1'b1; en_edge = cyc + 1;
    @(negedge clk);
    en[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (done[i]) begin at = cyc; break; end
    end
    if (at < 0) begin
      ncmp++; nfail++;
      $display("FAIL wait_done inst%0d: no word_done within %0d cycles", i, budget);
    end
  endtask

  function automatic int first_low();
    foreach (txlog[n]) if (txlog[n] == 1'b0) return n;
    return -1;
  endfunction

  // Recover byte k by sampling mid-bit relative to the first start bit.
  function automatic logic [7:0] rx_byte(input int k, input int bd, input int s);
    logic [7:0] v;
    int p;
    for (int b = 0; b < 8; b++) begin
      p = s + (10 * k + 1 + b) * bd + bd / 2;
      v[b] = (s >= 0 && p < txlog.size()) ? txlog[p] : 1'bx;
    end
    return v;
  endfunction

  initial begin
    int t, t0, t1, t2, s, nd;
    logic [127:0] wk [17];
    logic [31:0]  w40;
    logic [7:0]   e40 [4];
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; wr_en[i] = 1'b0; en[i] = 1'b0; din[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", i, 32'(tx[i]), 32'd1);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_empty", i, 32'(empty[i]), 32'd1);
      chk("rst_level", i, 32'(lvl[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf[i]), 32'd0);
      rst_n[i] = 1'b1;
    end

    // Default instance: one word, 01..08 on the line, 17281-cycle latency.
    wr(0, 128'h0807060504030201);
    txlog.delete(); log_sel = 0;
    pulse_en(0);
    wait_done(0, 18000, t);
    chk("latency_default", 0, 32'(t - en_edge), 32'd17281);
    s = first_low();
    for (int k = 0; k < 8; k++) chk("byte_default", 0, 32'(rx_byte(k, 216, s)), 32'(k + 1));
    log_sel = -1;

    // MSB-first 4-byte word.
    wr(1, 128'hA1B2C3D4);
    txlog.delete(); log_sel = 1;
    pulse_en(1);
    wait_done(1, 400, t);
    s = first_low();
    chk("tx_fall_after_load", 1, 32'(s), 32'd1);
    chk("line_activity", 1, 32'(t - (en_edge + s)), 32'd160);
    w40 = 32'hA1B2C3D4;
    for (int k = 0; k < 4; k++) e40[k] = w40[8*(3-k) +: 8];
    for (int k = 0; k < 4; k++) chk("byte_msb", 1, 32'(rx_byte(k, 4, s)), 32'(e40[k]));
    log_sel = -1;

    // Fill to 16, 17th write dropped.
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      wk[k] = {$urandom, $urandom, $urandom, $urandom};
      din[1] = wk[k]; wr_en[1] = 1'b1;
      @(negedge clk);
      if (k == 15) begin
        chk("full_at_16", 1, 32'(full[1]), 32'd1);
        chk("level_at_16", 1, 32'(lvl[1]), 32'd16);
        chk("ovf_before_17", 1, 32'(ovf[1]), 32'd0);
      end
    end
    wr_en[1] = 1'b0;
    chk("ovf_after_17", 1, 32'(ovf[1]), 32'd1);
    chk("level_after_17", 1, 32'(lvl[1]), 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin txlog.delete(); log_sel = 1; end
      pulse_en(1);
      wait_done(1, 400, t);
    end
    s = first_low();
    for (int k = 0; k < 4; k++) chk("drain_last_word", 1, 32'(rx_byte(k, 4, s)), 32'(wk[15][8*(3-k) +: 8]));
    log_sel = -1;
    chk("drained_empty", 1, 32'(empty[1]), 32'd1);
    chk("ovf_sticky", 1, 32'(ovf[1]), 32'd1);

    // Enable while busy and while empty is ignored.
    wr(1, {$urandom, $urandom, $urandom, $urandom});
    wr(1, {$urandom, $urandom, $urandom, $urandom});
    pulse_en(1);
    repeat (50) @(negedge clk);
    pulse_en(1);
    chk("level_en_busy", 1, 32'(lvl[1]), 32'd1);
    wait_done(1, 400, t);
    repeat (3) @(negedge clk);
    chk("level_after_word", 1, 32'(lvl[1]), 32'd1);
    pulse_en(1);
    wait_done(1, 400, t);
    pulse_en(1);
    repeat (3) @(negedge clk);
    chk("busy_en_empty", 1, 32'(busy[1]), 32'd0);

    // Reset during DATA of the third byte.
    wr(1, {$urandom, $urandom, $urandom, $urandom});
    wr(1, {$urandom, $urandom, $urandom, $urandom});
    pulse_en(1);
    repeat (88) @(negedge clk);
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tx", 1, 32'(tx[1]), 32'd1);
    chk("rst_mid_busy", 1, 32'(busy[1]), 32'd0);
    chk("rst_mid_level", 1, 32'(lvl[1]), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    nd = 0;
    repeat (200) begin @(posedge clk); #1; if (done[1]) nd++; end
    chk("no_done_after_rst", 1, 32'(nd), 32'd0);

    // Auto mode: three words without enable, pulses 121 cycles apart.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      din[2] = {$urandom, $urandom, $urandom, $urandom}; wr_en[2] = 1'b1;
      @(negedge clk);
    end
    wr_en[2] = 1'b0;
    wait_done(2, 300, t0);
    wait_done(2, 300, t1);
    wait_done(2, 300, t2);
    chk("auto_gap1", 2, 32'(t1 - t0), 32'd121);
    chk("auto_gap2", 2, 32'(t2 - t1), 32'd121);
    repeat (3) @(negedge clk);
    chk("auto_empty", 2, 32'(empty[2]), 32'd1);
    chk("auto_idle", 2, 32'(busy[2]), 32'd0);

    // Random traffic on the fast instances, stray enables on the idle default one.
    repeat (4000) begin
      @(negedge clk);
      en[0] = ($urandom_range(0, 7) == 0);
      for (int i = 1; i < NI; i++) begin
        wr_en[i] = ($urandom_range(0, 3) == 0);
        din[i]   = {$urandom, $urandom, $urandom, $urandom};
        en[i]    = ($urandom_range(0, 15) == 0);
      end
      rst_n[1] = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      wr_en[i] = 1'b0; en[i] = 1'b0; rst_n[i] = 1'b1;
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
